// File: rtl/modadd_arbiter.sv
// rtl/modadd_arbiter.sv - round-robin shared 255-bit modular adder with operand and result registers.
// Optional subtract path is enabled by defining MODADD_SUB_EN.
module modadd_arbiter #(
  parameter int WIDTH = 255,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [WIDTH-1:0]      i_q,
  input  logic [NREQ-1:0]       i_req_valid,
  input  logic [NREQ*WIDTH-1:0] i_req_a,
  input  logic [NREQ*WIDTH-1:0] i_req_b,
  input  logic [NREQ-1:0]       i_req_op,
  output logic [NREQ-1:0]       o_req_ready,
  output logic                  o_rsp_valid,
  output logic [IDW-1:0]        o_rsp_id,
  output logic [WIDTH-1:0]      o_rsp_data,
  input  logic                  i_rsp_ready
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [IDW-1:0]   s1_id;
  logic [IDW-1:0]   ptr;

  logic             adv2;
  logic             accept;
  logic             handshake;
  logic             found;
  logic [IDW-1:0]   gnt_idx;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH+1:0] reduced;
  logic [WIDTH-1:0] result;

  assign adv2   = s1_valid & (~o_rsp_valid | i_rsp_ready);
  assign accept = ~s1_valid | adv2;

  // Search ptr+1, ptr+2, ... with wrap; the subtract form avoids overflow when NREQ < 2^IDW.
  always_comb begin : grant_search
    logic [IDW-1:0] cand;
    found   = 1'b0;
    gnt_idx = ptr;
    cand    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = (ptr >= IDW'(NREQ - i)) ? ptr - IDW'(NREQ - i) : ptr + IDW'(i);
      if (!found && i_req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    if (found && accept && i_rst_n) begin
      o_req_ready[gnt_idx] = 1'b1;
    end
  end

  assign handshake = |o_req_ready;
  assign a_sel     = i_req_a[gnt_idx*WIDTH +: WIDTH];
  assign b_sel     = i_req_b[gnt_idx*WIDTH +: WIDTH];

`ifdef MODADD_SUB_EN
  // Negate B ahead of S1 so the shared adder computes A-B mod Q at unchanged latency.
  assign b_eff = (i_req_op[gnt_idx] && (b_sel != '0)) ? i_q - b_sel : b_sel;
`else
  logic unused_op;
  assign unused_op = ^i_req_op;
  assign b_eff     = b_sel;
`endif

  // A+B-Q non-negative (no borrow into the top bit) selects the reduced value.
  assign sum     = {1'b0, s1_a} + {1'b0, s1_b};
  assign reduced = {1'b0, sum} - {2'b00, i_q};
  assign result  = reduced[WIDTH+1] ? sum[WIDTH-1:0] : reduced[WIDTH-1:0];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid    <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_id       <= '0;
      ptr         <= IDW'(NREQ - 1);
      o_rsp_valid <= 1'b0;
      o_rsp_id    <= '0;
      o_rsp_data  <= '0;
    end else begin
      if (accept) begin
        s1_valid <= handshake;
        s1_a     <= a_sel;
        s1_b     <= b_eff;
        s1_id    <= gnt_idx;
      end
      if (handshake) begin
        ptr <= gnt_idx;
      end
      if (adv2) begin
        o_rsp_valid <= 1'b1;
        o_rsp_id    <= s1_id;
        o_rsp_data  <= result;
      end else if (i_rsp_ready) begin
        o_rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_modadd_arbiter.sv
// tb/tb_modadd_arbiter.sv - randomized and directed self-checking bench for modadd_arbiter.
module tb_modadd_arbiter;
  localparam int W  = 255;
  localparam int N  = 4;
  localparam int IW = 2;
`ifdef MODADD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   q;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   req_op = '0;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_ready = 1'b0;

  always #5 clk = ~clk;

  modadd_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_q(q),
    .i_req_valid(req_valid), .i_req_a(req_a), .i_req_b(req_b), .i_req_op(req_op),
    .o_req_ready(req_ready), .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id),
    .o_rsp_data(rsp_data), .i_rsp_ready(rsp_ready)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  // Stimulus held by the bench between steps.
  logic [W-1:0] ta [N];
  logic [W-1:0] tb_b [N];
  logic [N-1:0] tv = '0;
  logic [N-1:0] top = '0;
  logic [N-1:0] pend = '0;
  logic         trr = 1'b1;
  logic [N-1:0] dut_g;
  logic [N-1:0] last_g;

  // Reference model: an operand slot and an output slot holding expected results.
  logic          m_s1v, m_outv;
  logic [IW-1:0] m_s1id, m_outid;
  logic [W-1:0]  m_s1d, m_outd;
  int            m_ptr;

  function automatic logic [W-1:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    logic [W+1:0] aa, bb, qq, r;
    aa = {2'b00, a};
    bb = {2'b00, b};
    qq = {2'b00, q};
    if (op && SUB_EN) r = (aa + qq - bb) % qq;
    else              r = (aa + bb) % qq;
    return r[W-1:0];
  endfunction

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g;
    logic adv, acc;
    g   = '0;
    adv = m_s1v && (!m_outv || trr);
    acc = !m_s1v || adv;
    if (rst_n && acc) begin
      for (int i = 1; i <= N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (tv[k] && g == '0) g[k] = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic step();
    logic [N-1:0] eg;
    logic adv, acc;
    for (int k = 0; k < N; k++) begin
      req_a[k*W +: W] = ta[k];
      req_b[k*W +: W] = tb_b[k];
    end
    req_valid = tv;
    req_op    = top;
    rsp_ready = trr;
    #1;
    eg    = exp_grant();
    dut_g = req_ready;
    check("grant", (W+1)'(req_ready), (W+1)'(eg));
    check("rsp_valid", (W+1)'(rsp_valid), (W+1)'(m_outv));
    if (m_outv) begin
      check("rsp_id", (W+1)'(rsp_id), (W+1)'(m_outid));
      check("rsp_data", {1'b0, rsp_data}, {1'b0, m_outd});
    end
    if (!rst_n) begin
      m_s1v  = 1'b0;
      m_outv = 1'b0;
      m_ptr  = N - 1;
    end else begin
      adv = m_s1v && (!m_outv || trr);
      acc = !m_s1v || adv;
      if (adv) begin
        m_outv  = 1'b1;
        m_outid = m_s1id;
        m_outd  = m_s1d;
      end else if (trr) begin
        m_outv = 1'b0;
      end
      if (acc) begin
        m_s1v = (eg != '0);
        for (int k = 0; k < N; k++) begin
          if (eg[k]) begin
            m_s1id = IW'(k);
            m_s1d  = ref_res(ta[k], tb_b[k], top[k]);
            m_ptr  = k;
          end
        end
      end
    end
    last_g = eg;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst_valid", (W+1)'(rsp_valid), '0);
    check("rst_id", (W+1)'(rsp_id), '0);
    check("rst_data", {1'b0, rsp_data}, '0);
  endtask

  task automatic single(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic op, input logic [W-1:0] exp);
    tv = 4'b0001; ta[0] = a; tb_b[0] = b; top[0] = op; trr = 1'b1;
    step();
    tv = '0;
    step();
    check({tag, "_valid"}, (W+1)'(rsp_valid), (W+1)'(1));
    check({tag, "_id"}, (W+1)'(rsp_id), '0);
    check({tag, "_data"}, {1'b0, rsp_data}, {1'b0, exp});
    step();
  endtask

  function automatic logic [W-1:0] rnd_val();
    logic [255:0] r;
    int sel;
    sel = $urandom_range(0, 7);
    r   = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()};
    if (sel == 0) return '0;
    if (sel == 1) return q - 1;
    return r[W-1:0] % q;
  endfunction

  task automatic rand_run(input int n);
    for (int c = 0; c < n; c++) begin
      trr = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) begin
        if (!pend[k]) begin
          ta[k]   = rnd_val();
          tb_b[k] = ($urandom_range(0, 7) == 0) ? ((ta[k] == '0) ? '0 : q - ta[k]) : rnd_val();
          top[k]  = 1'($urandom_range(0, 1));
          tv[k]   = 1'($urandom_range(0, 1));
        end else begin
          tv[k] = ($urandom_range(0, 7) != 0);
        end
      end
      step();
      pend = tv & ~last_g;
    end
    tv = '0; pend = '0; trr = 1'b1;
    for (int c = 0; c < 4; c++) step();
  endtask

  initial begin
    q = '1;
    q = q - 18;
    for (int k = 0; k < N; k++) begin
      ta[k] = '0; tb_b[k] = '0;
    end
    @(posedge clk);
    #1;
    m_s1v = 1'b0; m_outv = 1'b0; m_ptr = N - 1;
    m_s1id = '0; m_outid = '0; m_s1d = '0; m_outd = '0;
    do_reset();

    single("add_5_7", 255'd5, 255'd7, 1'b0, 255'd12);
    single("add_max", q - 1, q - 1, 1'b0, q - 2);
    single("add_eq_q", 255'd10, q - 10, 1'b0, '0);
    single("add_zero", '0, '0, 1'b0, '0);
`ifdef MODADD_SUB_EN
    single("sub_3_5", 255'd3, 255'd5, 1'b1, q - 2);
    single("sub_7_0", 255'd7, '0, 1'b1, 255'd7);
`endif

    // Round robin with all requesters continuously valid.
    do_reset();
    for (int k = 0; k < N; k++) begin
      ta[k] = 255'(k + 1); tb_b[k] = 255'(100 * k); top[k] = 1'b0;
    end
    tv = 4'b1111; trr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [N-1:0] want;
      want = '0;
      want[i % N] = 1'b1;
      step();
      check("rr_order", (W+1)'(dut_g), (W+1)'(want));
    end
    tv = '0;
    for (int c = 0; c < 3; c++) step();

    // Backpressure with two requests in flight and a third waiting.
    tv = 4'b0011; trr = 1'b0;
    step();
    tv = 4'b0010;
    step();
    tv = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_ready", (W+1)'(dut_g), '0);
      check("bp_id", (W+1)'(rsp_id), '0);
    end
    tv = '0; trr = 1'b1;
    for (int c = 0; c < 3; c++) step();

    // Reset with both stages full.
    tv = 4'b0011; trr = 1'b0;
    step();
    tv = 4'b0010;
    step();
    tv = '0;
    do_reset();
    tv = 4'b1111; trr = 1'b1;
    step();
    check("rst_first_grant", (W+1)'(dut_g), (W+1)'(1));
    tv = '0;
    for (int c = 0; c < 3; c++) step();

    rand_run(400);

    q = 255'd13;
    do_reset();
    rand_run(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
